// File: rtl/aibcr3_dcc_intp_ctrl.sv
// aibcr3_dcc_intp_ctrl
// Closed-loop step controller for the 8-phase DCC interpolator. Phase-detector
// votes are integrated in a small signed filter. When the filter reaches the
// threshold, the select code moves by one Gray step and the loop then waits out
// a settle hold-off. The block also reports lock (dithering about the optimum)
// and saturation at either end of the code range. A static override is
// available for bring-up.

module aibcr3_dcc_intp_ctrl #(
    parameter int INIT_CODE  = 0,
    parameter int FILT_TH    = 4,
    parameter int SETTLE_CYC = 6,
    parameter int LOCK_CNT   = 3
) (
    input  logic       CLKIN,
    input  logic       PDb,
    input  logic       en,
    input  logic       ovrd_en,
    input  logic [2:0] ovrd_code,
    input  logic       pd_up,
    input  logic       pd_vld,
    output logic [2:0] gray,
    output logic [2:0] code,
    output logic       lock,
    output logic       sat_hi,
    output logic       sat_lo
);

    // Constants sized to the registers they are compared against
    localparam logic [2:0]        INIT_BIN  = 3'(INIT_CODE);
    localparam logic [2:0]        INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
    localparam logic signed [4:0] TH_POS    = 5'(FILT_TH);
    localparam logic signed [4:0] TH_NEG    = 5'(-FILT_TH);
    localparam logic [5:0]        SETTLE_LD = 6'(SETTLE_CYC);
    localparam logic [2:0]        LOCK_LD   = 3'(LOCK_CNT);
    localparam logic [2:0]        CODE_MAX  = 3'd7;
    localparam logic [2:0]        CODE_MIN  = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_TRACK
    } state_t;

    state_t            state;
    logic signed [4:0] filt;
    logic [5:0]        settle_cnt;
    logic [2:0]        rev_cnt;
    logic              prev_vld;
    logic              prev_up;

    logic signed [4:0] vote;
    logic signed [4:0] filt_sum;
    logic              hit_up;
    logic              hit_dn;
    logic              step_up;
    logic              step_dn;
    logic              step_any;
    logic [2:0]        code_step;
    logic              is_rev;
    logic              is_same;
    logic [2:0]        rev_inc;

    // Binary to reflected Gray, so adjacent codes differ in one bit
    function automatic logic [2:0] to_gray(input logic [2:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Filter update and step decision for the current vote
    always_comb begin
        vote      = pd_up ? 5'sd1 : -5'sd1;
        filt_sum  = filt + vote;
        hit_up    = (state == ST_TRACK) && pd_vld && (filt_sum == TH_POS);
        hit_dn    = (state == ST_TRACK) && pd_vld && (filt_sum == TH_NEG);
        step_up   = hit_up && (code != CODE_MAX);
        step_dn   = hit_dn && (code != CODE_MIN);
        step_any  = step_up || step_dn;
        code_step = step_up ? (code + 3'd1) : (code - 3'd1);
        is_rev    = prev_vld && (prev_up != step_up);
        is_same   = prev_vld && (prev_up == step_up);
        rev_inc   = (rev_cnt >= LOCK_LD) ? rev_cnt : (rev_cnt + 3'd1);
    end

    // Loop FSM with registered code, gray, lock and saturation outputs
    always_ff @(posedge CLKIN or negedge PDb) begin
        if (!PDb) begin
            state      <= ST_IDLE;
            code       <= INIT_BIN;
            gray       <= INIT_GRAY;
            filt       <= '0;
            settle_cnt <= '0;
            rev_cnt    <= '0;
            prev_vld   <= 1'b0;
            prev_up    <= 1'b0;
            lock       <= 1'b0;
            sat_hi     <= 1'b0;
            sat_lo     <= 1'b0;
        end else if (ovrd_en) begin
            state      <= ST_IDLE;
            code       <= ovrd_code;
            gray       <= to_gray(ovrd_code);
            filt       <= '0;
            settle_cnt <= '0;
            rev_cnt    <= '0;
            prev_vld   <= 1'b0;
            lock       <= 1'b0;
        end else if (!en) begin
            state      <= ST_IDLE;
            filt       <= '0;
            settle_cnt <= '0;
            rev_cnt    <= '0;
            prev_vld   <= 1'b0;
            lock       <= 1'b0;
            sat_hi     <= 1'b0;
            sat_lo     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= SETTLE_LD;
                    filt       <= '0;
                end
                ST_SETTLE: begin
                    if (settle_cnt <= 6'd1) begin
                        state      <= ST_TRACK;
                        settle_cnt <= '0;
                        filt       <= '0;
                    end else begin
                        settle_cnt <= settle_cnt - 6'd1;
                    end
                end
                ST_TRACK: begin
                    if (step_any) begin
                        code       <= code_step;
                        gray       <= to_gray(code_step);
                        filt       <= '0;
                        state      <= ST_SETTLE;
                        settle_cnt <= SETTLE_LD;
                        prev_vld   <= 1'b1;
                        prev_up    <= step_up;
                        if (is_rev) begin
                            rev_cnt <= rev_inc;
                            lock    <= (rev_inc >= LOCK_LD);
                        end else if (is_same) begin
                            rev_cnt <= '0;
                            lock    <= 1'b0;
                        end
                        if (step_up) begin
                            sat_lo <= 1'b0;
                        end else begin
                            sat_hi <= 1'b0;
                        end
                    end else if (hit_up) begin
                        filt   <= '0;
                        sat_hi <= 1'b1;
                    end else if (hit_dn) begin
                        filt   <= '0;
                        sat_lo <= 1'b1;
                    end else if (pd_vld) begin
                        filt <= filt_sum;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aibcr3_dcc_intp_ctrl.sv
// tb_aibcr3_dcc_intp_ctrl
// Randomised bench with a behavioural reference model. The driver pushes the
// expected post-edge outputs into a scoreboard. An independent monitor pops
// one entry after every clock edge and compares it with the DUT outputs.

module tb_aibcr3_dcc_intp_ctrl;

    localparam int INIT_CODE  = 0;
    localparam int FILT_TH    = 4;
    localparam int SETTLE_CYC = 6;
    localparam int LOCK_CNT   = 3;

    logic       CLKIN;
    logic       PDb;
    logic       en;
    logic       ovrd_en;
    logic [2:0] ovrd_code;
    logic       pd_up;
    logic       pd_vld;
    logic [2:0] gray;
    logic [2:0] code;
    logic       lock;
    logic       sat_hi;
    logic       sat_lo;

    typedef struct {
        int code;
        int gray;
        int lock;
        int hi;
        int lo;
    } exp_t;

    exp_t scb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int gray_tbl[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    int m_code;
    int running;
    int settle_left;
    int net;
    int last_dir;
    int reversals;
    int m_lock;
    int m_hi;
    int m_lo;

    aibcr3_dcc_intp_ctrl #(
        .INIT_CODE (INIT_CODE),
        .FILT_TH   (FILT_TH),
        .SETTLE_CYC(SETTLE_CYC),
        .LOCK_CNT  (LOCK_CNT)
    ) dut (
        .CLKIN    (CLKIN),
        .PDb      (PDb),
        .en       (en),
        .ovrd_en  (ovrd_en),
        .ovrd_code(ovrd_code),
        .pd_up    (pd_up),
        .pd_vld   (pd_vld),
        .gray     (gray),
        .code     (code),
        .lock     (lock),
        .sat_hi   (sat_hi),
        .sat_lo   (sat_lo)
    );

    initial CLKIN = 1'b0;
    always #5 CLKIN = ~CLKIN;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_code      = INIT_CODE;
        running     = 0;
        settle_left = 0;
        net         = 0;
        last_dir    = 0;
        reversals   = 0;
        m_lock      = 0;
        m_hi        = 0;
        m_lo        = 0;
    endfunction

    function automatic void model_take_step(input int dir);
        m_code      = m_code + dir;
        net         = 0;
        settle_left = SETTLE_CYC;
        if (last_dir == -dir) begin
            if (reversals < LOCK_CNT) reversals++;
            m_lock = (reversals >= LOCK_CNT) ? 1 : 0;
        end else if (last_dir == dir) begin
            reversals = 0;
            m_lock    = 0;
        end
        last_dir = dir;
        if (dir > 0) m_lo = 0;
        else         m_hi = 0;
    endfunction

    // One clock of loop behaviour, following the priority override > disable > loop
    function automatic void model_step(input int e, input int o, input int oc,
                                       input int up, input int vld);
        if (o != 0) begin
            m_code      = oc;
            running     = 0;
            settle_left = 0;
            net         = 0;
            reversals   = 0;
            last_dir    = 0;
            m_lock      = 0;
        end else if (e == 0) begin
            running     = 0;
            settle_left = 0;
            net         = 0;
            reversals   = 0;
            last_dir    = 0;
            m_lock      = 0;
            m_hi        = 0;
            m_lo        = 0;
        end else if (running == 0) begin
            running     = 1;
            settle_left = SETTLE_CYC;
            net         = 0;
        end else if (settle_left > 0) begin
            settle_left--;
        end else if (vld != 0) begin
            net = net + ((up != 0) ? 1 : -1);
            if (net == FILT_TH) begin
                net = 0;
                if (m_code < 7) model_take_step(1);
                else            m_hi = 1;
            end else if (net == -FILT_TH) begin
                net = 0;
                if (m_code > 0) model_take_step(-1);
                else            m_lo = 1;
            end
        end
    endfunction

    function automatic exp_t model_view();
        exp_t x;
        x.code = m_code;
        x.gray = gray_tbl[m_code];
        x.lock = m_lock;
        x.hi   = m_hi;
        x.lo   = m_lo;
        return x;
    endfunction

    task automatic apply_stimulus(input int e, input int o, input int oc,
                                  input int up, input int vld);
        @(negedge CLKIN);
        PDb       = 1'b1;
        en        = (e != 0);
        ovrd_en   = (o != 0);
        ovrd_code = 3'(oc);
        pd_up     = (up != 0);
        pd_vld    = (vld != 0);
        model_step(e, o, oc, up, vld);
        scb.push_back(model_view());
    endtask

    task automatic check_now(input string tag);
        exp_t x;
        x = model_view();
        check_output({tag, "_code"}, int'(code), x.code);
        check_output({tag, "_gray"}, int'(gray), x.gray);
        check_output({tag, "_lock"}, int'(lock), x.lock);
        check_output({tag, "_sat_hi"}, int'(sat_hi), x.hi);
        check_output({tag, "_sat_lo"}, int'(sat_lo), x.lo);
    endtask

    // Asynchronous reset between edges; outputs must respond without a clock
    task automatic pulse_reset();
        @(negedge CLKIN);
        #2;
        PDb = 1'b0;
        #1;
        model_reset();
        check_now("async_reset");
    endtask

    task automatic step_once(input int dir);
        int start;
        bit moved;
        start = m_code;
        moved = 0;
        for (int i = 0; i < 200 && !moved; i++) begin
            apply_stimulus(1, 0, 0, (dir > 0) ? 1 : 0, 1);
            if (m_code != start) moved = 1;
        end
        if (!moved) begin
            checks++;
            errors++;
            $display("[TB] FAIL step_budget: code stayed at %0d, wanted a move of %0d", start, dir);
        end
    endtask

    // Monitor: one scoreboard entry per clock edge
    initial begin
        exp_t x;
        forever begin
            @(posedge CLKIN);
            #1;
            if (scb.size() != 0) begin
                x = scb.pop_front();
                check_output("code", int'(code), x.code);
                check_output("gray", int'(gray), x.gray);
                check_output("lock", int'(lock), x.lock);
                check_output("sat_hi", int'(sat_hi), x.hi);
                check_output("sat_lo", int'(sat_lo), x.lo);
            end
        end
    end

    // Stimulus sequence
    initial begin
        int dirs[5] = '{1, -1, 1, -1, -1};
        int bias;
        int n;

        PDb       = 1'b0;
        en        = 1'b0;
        ovrd_en   = 1'b0;
        ovrd_code = 3'd0;
        pd_up     = 1'b0;
        pd_vld    = 1'b0;
        model_reset();
        repeat (2) @(posedge CLKIN);
        #1;
        check_now("reset");

        $display("[TB] Walking the code up to saturation");
        for (int i = 0; i < 100; i++) apply_stimulus(1, 0, 0, 1, 1);

        $display("[TB] Walking the code down to saturation");
        for (int i = 0; i < 100; i++) apply_stimulus(1, 0, 0, 0, 1);

        $display("[TB] Dithering about code 3 for lock");
        for (int i = 0; i < 8 && m_code != 3; i++) step_once(1);
        foreach (dirs[k]) step_once(dirs[k]);

        $display("[TB] Sparse valid votes");
        for (int i = 0; i < 60; i++) apply_stimulus(1, 0, 0, 1, i % 2);

        $display("[TB] Override mid-settle");
        step_once(-1);
        apply_stimulus(1, 0, 0, 1, 1);
        apply_stimulus(1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 5, 1, 1);
        for (int i = 0; i < 30; i++) apply_stimulus(1, 0, 0, 1, 1);

        $display("[TB] Loop disable mid-run");
        for (int i = 0; i < 10; i++) apply_stimulus(0, 0, 0, 1, 1);
        for (int i = 0; i < 20; i++) apply_stimulus(1, 0, 0, 0, 1);

        $display("[TB] Reset while tracking");
        n = 0;
        while (n < 200 && !(running != 0 && settle_left == 0 && net != 0)) begin
            apply_stimulus(1, 0, 0, 1, 1);
            n++;
        end
        pulse_reset();
        for (int i = 0; i < 30; i++) apply_stimulus(1, 0, 0, 1, 1);

        $display("[TB] Randomised run");
        bias = 80;
        for (int i = 0; i < 1500; i++) begin
            if (i % 64 == 0) bias = ($urandom_range(0, 1) != 0) ? 85 : 15;
            if ($urandom_range(0, 499) == 0) pulse_reset();
            apply_stimulus(($urandom_range(0, 99) != 0) ? 1 : 0,
                           ($urandom_range(0, 99) < 2) ? 1 : 0,
                           int'($urandom_range(0, 7)),
                           ($urandom_range(0, 99) < bias) ? 1 : 0,
                           ($urandom_range(0, 3) != 0) ? 1 : 0);
        end

        @(posedge CLKIN);
        #3;
        if (scb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", scb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
